// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV64I fetch stage: default parameters, FSM state
// encoding and the redirect-alignment helper.
package fetch_unit_pkg;

    localparam int          XLEN_DEF      = 64;
    localparam logic [63:0] RESET_PC_DEF  = 64'h0;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    // Without compressed instructions a target must be 4-byte aligned once bit0 is dropped.
    function automatic logic target_misaligned(input logic [1:0] target_low);
        return target_low[1];
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline stage register carrying PC, link value and instruction word.
// Bubble wins over load; with neither asserted the contents hold.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [31:0]     instr_q;

    // Stage register update: bubble keeps the PC fields and only invalidates the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP_INSTR;
        end else if (bubble_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
            instr_q    <= instr_i;
        end else begin
            valid_q    <= valid_q;
            pc_q       <= pc_q;
            pc_plus4_q <= pc_plus4_q;
            instr_q    <= instr_q;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// RV64I instruction-fetch stage: PC register, next-PC selection, BOOT/RUN/HALT
// control, misaligned-redirect trap and a count of captured instructions.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0],
    parameter logic [31:0]    NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [63:0]     fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic [63:0]     count_q, count_d;
    logic            load_s;
    logic            bubble_s;
    logic [XLEN-1:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

    // Next-state selection; in RUN a redirect outranks stall, which outranks advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        count_d      = count_q;
        load_s       = 1'b0;
        bubble_s     = 1'b0;
        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    bubble_s = 1'b1;
                    if (target_misaligned(redirect_target[1:0])) begin
                        state_d      = FS_HALT;
                        fault_d      = 1'b1;
                        fault_addr_d = redirect_target;
                    end else begin
                        pc_d = {redirect_target[XLEN-1:1], 1'b0};
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    load_s  = 1'b1;
                    pc_d    = pc_plus4_s;
                    count_d = count_q + 64'd1;
                end
            end
            FS_HALT: begin
                bubble_s = 1'b1;
            end
            default: begin
                state_d  = FS_HALT;
                bubble_s = 1'b1;
            end
        endcase
    end

    // Control state, PC, fault capture and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_BOOT;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            count_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            count_q      <= count_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .bubble_i   (bubble_s),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4_s),
        .instr_i    (imem_instr),
        .valid_o    (id_valid),
        .pc_o       (id_pc),
        .pc_plus4_o (id_pc_plus4),
        .instr_o    (id_instr)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fault_addr  = fault_addr_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, redirect, trap, stall, wrap and async reset.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JALR = 32'h0080_8567;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = 64'd0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        fetch_fault;
    logic [63:0] fault_addr;
    logic [63:0] fetch_count;

    logic        w_rst_n = 1'b0;
    logic [63:0] w_imem_addr;
    logic        w_id_valid;
    logic [63:0] w_id_pc;
    logic [63:0] w_id_pc_plus4;
    logic [31:0] w_id_instr;
    logic        w_fetch_fault;
    logic [63:0] w_fault_addr;
    logic [63:0] w_fetch_count;

    logic jalr_mode = 1'b0;
    logic pat_mode  = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory: NOP, or a pattern {addr[31:2],2'b11}, with optional JALR at 0.
    always_comb begin
        if (jalr_mode && imem_addr == 64'd0) begin
            imem_instr = JALR;
        end else if (pat_mode) begin
            imem_instr = {imem_addr[31:2], 2'b11};
        end else begin
            imem_instr = NOP;
        end
    end

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_instr        (id_instr),
        .fetch_fault     (fetch_fault),
        .fault_addr      (fault_addr),
        .fetch_count     (fetch_count)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
        .clk             (clk),
        .rst_n           (w_rst_n),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (64'd0),
        .imem_addr       (w_imem_addr),
        .imem_instr      (NOP),
        .id_valid        (w_id_valid),
        .id_pc           (w_id_pc),
        .id_pc_plus4     (w_id_pc_plus4),
        .id_instr        (w_id_instr),
        .fetch_fault     (w_fetch_fault),
        .fault_addr      (w_fault_addr),
        .fetch_count     (w_fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {63'd0, id_valid}, 64'd0);
        check({tag, "_pc"}, id_pc, 64'd0);
        check({tag, "_pc4"}, id_pc_plus4, 64'd0);
        check({tag, "_instr"}, {32'd0, id_instr}, {32'd0, NOP});
        check({tag, "_fault"}, {63'd0, fetch_fault}, 64'd0);
        check({tag, "_faddr"}, fault_addr, 64'd0);
        check({tag, "_count"}, fetch_count, 64'd0);
        check({tag, "_addr"}, imem_addr, 64'd0);
    endtask

    initial begin
        // 1. Reset and boot with all-NOP memory
        #12;
        check_reset_state("rst");
        rst_n = 1'b1;
        tick();
        check("boot_valid", {63'd0, id_valid}, 64'd0);
        check("boot_addr", imem_addr, 64'd0);
        tick();
        check("f0_valid", {63'd0, id_valid}, 64'd1);
        check("f0_pc", id_pc, 64'd0);
        check("f0_pc4", id_pc_plus4, 64'd4);
        check("f0_instr", {32'd0, id_instr}, {32'd0, NOP});
        check("f0_count", fetch_count, 64'd1);
        tick();
        check("f1_pc", id_pc, 64'd4);
        tick();
        check("f2_pc", id_pc, 64'd8);
        check("f2_count", fetch_count, 64'd3);
        check("f2_addr", imem_addr, 64'd12);

        // 4. Stall for three cycles, then stall together with redirect
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", id_pc, 64'd8);
            check("stall_addr", imem_addr, 64'd12);
            check("stall_count", fetch_count, 64'd3);
            check("stall_valid", {63'd0, id_valid}, 64'd1);
        end
        redirect_valid  = 1'b1;
        redirect_target = 64'h100;
        tick();
        check("sr_valid", {63'd0, id_valid}, 64'd0);
        check("sr_addr", imem_addr, 64'h100);
        check("sr_count", fetch_count, 64'd3);
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check("sr_tgt_pc", id_pc, 64'h100);
        check("sr_tgt_count", fetch_count, 64'd4);
        pat_mode = 1'b1;
        tick();
        check("pat_pc", id_pc, 64'h104);
        check("pat_instr", {32'd0, id_instr}, 64'h107);
        check("pat_pc4", id_pc_plus4, 64'h108);

        // 6a. Asynchronous reset while stalled
        stall = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        check_reset_state("arst_stall");

        // 2. JALR at word 0, redirect to 72
        jalr_mode = 1'b1;
        stall = 1'b0;
        rst_n = 1'b1;
        tick();
        check("b2_valid", {63'd0, id_valid}, 64'd0);
        tick();
        check("j_pc", id_pc, 64'd0);
        check("j_instr", {32'd0, id_instr}, {32'd0, JALR});
        check("j_addr", imem_addr, 64'd4);
        redirect_valid  = 1'b1;
        redirect_target = 64'd72;
        tick();
        check("j_bubble", {63'd0, id_valid}, 64'd0);
        check("j_bub_instr", {32'd0, id_instr}, {32'd0, NOP});
        check("j_addr2", imem_addr, 64'h48);
        redirect_valid = 1'b0;
        tick();
        check("j_tgt_pc", id_pc, 64'h48);
        check("j_tgt_valid", {63'd0, id_valid}, 64'd1);
        check("j_tgt_instr", {32'd0, id_instr}, 64'h4B);
        check("j_tgt_count", fetch_count, 64'd2);

        // 3. Odd target drops bit0; bit1 set traps
        redirect_valid  = 1'b1;
        redirect_target = 64'h49;
        tick();
        check("odd_addr", imem_addr, 64'h48);
        check("odd_fault", {63'd0, fetch_fault}, 64'd0);
        redirect_valid = 1'b0;
        tick();
        check("odd_pc", id_pc, 64'h48);
        check("odd_count", fetch_count, 64'd3);
        redirect_valid  = 1'b1;
        redirect_target = 64'h4A;
        tick();
        check("trap_fault", {63'd0, fetch_fault}, 64'd1);
        check("trap_faddr", fault_addr, 64'h4A);
        check("trap_addr", imem_addr, 64'h4C);
        check("trap_valid", {63'd0, id_valid}, 64'd0);
        redirect_target = 64'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("halt_addr", imem_addr, 64'h4C);
        check("halt_valid", {63'd0, id_valid}, 64'd0);
        check("halt_fault", {63'd0, fetch_fault}, 64'd1);
        check("halt_faddr", fault_addr, 64'h4A);
        check("halt_count", fetch_count, 64'd3);

        // 6b. Asynchronous reset in HALT, then resume from BOOT
        rst_n = 1'b0;
        #2;
        check_reset_state("arst_halt");
        rst_n = 1'b1;
        tick();
        check("rb_valid", {63'd0, id_valid}, 64'd0);
        tick();
        check("rb_valid2", {63'd0, id_valid}, 64'd1);
        check("rb_pc", id_pc, 64'd0);
        check("rb_count", fetch_count, 64'd1);

        // 5. PC wrap from RESET_PC near the top of the address space
        check("w_rst_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        w_rst_n = 1'b1;
        tick();
        check("w_boot_valid", {63'd0, w_id_valid}, 64'd0);
        tick();
        check("w_c0_pc", w_id_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        check("w_c0_pc4", w_id_pc_plus4, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("w_c1_pc", w_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("w_c1_pc4", w_id_pc_plus4, 64'd0);
        check("w_addr", w_imem_addr, 64'd0);
        check("w_count", w_fetch_count, 64'd2);
        check("w_fault", {63'd0, w_fetch_fault}, 64'd0);
        check("w_faddr", w_fault_addr, 64'd0);
        check("w_instr", {32'd0, w_id_instr}, {32'd0, NOP});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
